// File: rtl/reg_file_mp.sv
// reg_file_mp: LEGv8 multi-read-port register file with XZR, async reset and a sequential clear engine.
// Define REG_FILE_BYPASS_EN to forward same-edge write data to matching read ports.
module reg_file_mp #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reg_write,
    input  logic [ADDR_W-1:0]        wn,
    input  logic [DATA_W-1:0]        wd,
    input  logic [NUM_RD*ADDR_W-1:0] rn,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     clear_req,
    output logic                     busy
);
    localparam int                DEPTH    = 2**ADDR_W;
    localparam bit                ZERO_EN  = (ZERO_REG >= 0);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ZERO_EN ? ADDR_W'(ZERO_REG) : '0;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
`ifdef REG_FILE_BYPASS_EN
    localparam bit                BYPASS   = 1'b1;
`else
    localparam bit                BYPASS   = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_q, rd_d;
    logic                     busy_s;
    logic                     we_s;

    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return ZERO_EN && (addr == ZERO_IDX);
    endfunction

    // State register: clear-engine state and entry counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: clear walks entries 0..DEPTH-1, requests during a clear are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: busy flag and qualified write enable.
    always_comb begin
        busy_s = (state_q == ST_CLEAR);
        we_s   = reg_write && !busy_s && !is_zero(wn);
    end

    // Storage array: clear engine has priority, normal writes are locked out while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (busy_s) begin
            mem_q[cnt_q] <= '0;
        end else if (we_s) begin
            mem_q[wn] <= wd;
        end
    end

    // Read-port next values: zero while busy or on XZR, optional same-edge forwarding.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (busy_s || is_zero(rn[i*ADDR_W +: ADDR_W])) begin
                rd_d[i*DATA_W +: DATA_W] = '0;
            end else if (BYPASS && we_s && (wn == rn[i*ADDR_W +: ADDR_W])) begin
                rd_d[i*DATA_W +: DATA_W] = wd;
            end else begin
                rd_d[i*DATA_W +: DATA_W] = mem_q[rn[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    // Registered read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd   = rd_q;
    assign busy = busy_s;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed table, clear/reset sequences and random traffic
// against an array-based reference model; two instances cover ZERO_REG=31 and ZERO_REG=-1.
module tb_reg_file_mp;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         reg_write;
    logic [4:0]   wn;
    logic [63:0]  wd;
    logic [9:0]   rn;
    logic         clear_req;
    logic [127:0] rd_a, rd_b;
    logic         busy_a, busy_b;

    reg_file_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(31)) u_dut_a (
        .clk(clk), .reset(reset), .reg_write(reg_write), .wn(wn), .wd(wd),
        .rn(rn), .rd(rd_a), .clear_req(clear_req), .busy(busy_a)
    );

    reg_file_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(-1)) u_dut_b (
        .clk(clk), .reset(reset), .reg_write(reg_write), .wn(wn), .wd(wd),
        .rn(rn), .rd(rd_b), .clear_req(clear_req), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: register contents per instance, clear position (-1 = idle), expected outputs.
    logic [63:0] m_a [32];
    logic [63:0] m_b [32];
    int          clr_pos;
    logic [63:0] e_a [2];
    logic [63:0] e_b [2];
    logic        e_busy;

    typedef struct {
        logic        w;
        logic [4:0]  wn;
        logic [63:0] wd;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [63:0] xa0;
        logic [63:0] xa1;
        logic [63:0] xb0;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_a[k] = 64'd0;
            m_b[k] = 64'd0;
        end
        clr_pos = -1;
        e_a[0] = 64'd0; e_a[1] = 64'd0;
        e_b[0] = 64'd0; e_b[1] = 64'd0;
        e_busy = 1'b0;
    endtask

    task automatic model_edge();
        bit       busy_now;
        bit       we;
        bit [4:0] addr;
        busy_now = (clr_pos >= 0);
        we       = reg_write && !busy_now;
        for (int p = 0; p < 2; p++) begin
            addr = rn[p*5 +: 5];
            if (busy_now) begin
                e_a[p] = 64'd0;
                e_b[p] = 64'd0;
            end else begin
                if (addr == 5'd31)                                  e_a[p] = 64'd0;
                else if (BYP && we && wn == addr)                   e_a[p] = wd;
                else                                                e_a[p] = m_a[addr];
                if (BYP && we && wn == addr)                        e_b[p] = wd;
                else                                                e_b[p] = m_b[addr];
            end
        end
        if (busy_now) begin
            m_a[clr_pos] = 64'd0;
            m_b[clr_pos] = 64'd0;
            clr_pos = (clr_pos == 31) ? -1 : clr_pos + 1;
        end else begin
            if (we && wn != 5'd31) m_a[wn] = wd;
            if (we)                m_b[wn] = wd;
            if (clear_req)         clr_pos = 0;
        end
        e_busy = (clr_pos >= 0);
    endtask

    task automatic step(input logic w, input logic [4:0] a, input logic [63:0] d,
                        input logic [4:0] r0, input logic [4:0] r1, input logic c);
        reg_write = w; wn = a; wd = d; rn = {r1, r0}; clear_req = c;
        model_edge();
        @(posedge clk);
        #1;
        check("a_rd0",  rd_a[63:0],   e_a[0]);
        check("a_rd1",  rd_a[127:64], e_a[1]);
        check("b_rd0",  rd_b[63:0],   e_b[0]);
        check("b_rd1",  rd_b[127:64], e_b[1]);
        check("a_busy", {63'd0, busy_a}, {63'd0, e_busy});
        check("b_busy", {63'd0, busy_b}, {63'd0, e_busy});
    endtask

    task automatic reset_now_and_check(input string tag);
        #1 reset = 1'b1;
        #1;
        check({tag, "_busy"}, {62'd0, busy_a, busy_b}, 64'd0);
        check({tag, "_rd_a"}, rd_a[63:0] | rd_a[127:64], 64'd0);
        check({tag, "_rd_b"}, rd_b[63:0] | rd_b[127:64], 64'd0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic busy_window(input string tag, input bit extra_traffic);
        int cnt;
        step(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b1);
        cnt = busy_a ? 1 : 0;
        for (int k = 1; k <= 36; k++) begin
            if (extra_traffic && k == 5)      step(1'b1, 5'd1, 64'h55, 5'd1, 5'd2, 1'b0);
            else if (extra_traffic && k == 8) step(1'b0, 5'd0, 64'd0, 5'd3, 5'd4, 1'b1);
            else                              step(1'b0, 5'd0, 64'd0, 5'($urandom_range(0, 31)),
                                                   5'($urandom_range(0, 31)), 1'b0);
            if (busy_a) cnt++;
        end
        check({tag, "_busy_cycles"}, 64'(cnt), 64'd32);
    endtask

    initial begin
        reset = 1'b1; reg_write = 1'b0; wn = '0; wd = '0; rn = '0; clear_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_a", rd_a[63:0] | rd_a[127:64], 64'd0);
        check("rst_busy", {62'd0, busy_a, busy_b}, 64'd0);
        reset = 1'b0;

        tbl[0] = '{1'b1, 5'd3,  64'h0123_4567_89AB_CDEF, 5'd5,  5'd4,  64'd0, 64'd0, 64'd0};
        tbl[1] = '{1'b0, 5'd0,  64'd0, 5'd3, 5'd3, 64'h0123_4567_89AB_CDEF,
                   64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        tbl[2] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 5'd0,
                   64'h0123_4567_89AB_CDEF, 64'd0, 64'h0123_4567_89AB_CDEF};
        tbl[3] = '{1'b0, 5'd0,  64'd0, 5'd31, 5'd31, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[4] = '{1'b1, 5'd7,  64'h11, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0};
        tbl[5] = '{1'b1, 5'd7,  64'h22, 5'd7, 5'd3, BYP ? 64'h22 : 64'h11,
                   64'h0123_4567_89AB_CDEF, BYP ? 64'h22 : 64'h11};
        tbl[6] = '{1'b0, 5'd0,  64'd0, 5'd7, 5'd31, 64'h22, 64'd0, 64'h22};
        tbl[7] = '{1'b1, 5'd31, 64'hAAAA_AAAA_AAAA_AAAA, 5'd31, 5'd7, 64'd0, 64'h22,
                   BYP ? 64'hAAAA_AAAA_AAAA_AAAA : 64'hFFFF_FFFF_FFFF_FFFF};

        for (int v = 0; v < 8; v++) begin
            step(tbl[v].w, tbl[v].wn, tbl[v].wd, tbl[v].r0, tbl[v].r1, 1'b0);
            check($sformatf("tbl%0d_a0", v), rd_a[63:0],   tbl[v].xa0);
            check($sformatf("tbl%0d_a1", v), rd_a[127:64], tbl[v].xa1);
            check($sformatf("tbl%0d_b0", v), rd_b[63:0],   tbl[v].xb0);
        end

        // Asynchronous reset between edges, then X5/X3 read back as zero.
        reset_now_and_check("async_rst");
        step(1'b0, 5'd0, 64'd0, 5'd5, 5'd3, 1'b0);
        check("post_rst_x5", rd_a[63:0], 64'd0);

        // Fill X0..X30 (and X31 on the no-XZR instance), then run a clear with disturbances.
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 5'(i), 64'(i + 1) * 64'h0101_0101_0101_0101, 5'(i), 5'd0, 1'b0);
        end
        busy_window("clr", 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 5'd0, 64'd0, 5'(2 * i), 5'(2 * i + 1), 1'b0);
            check("clr_zero_a", rd_a[63:0] | rd_a[127:64], 64'd0);
            check("clr_zero_b", rd_b[63:0] | rd_b[127:64], 64'd0);
        end

        // Reset at clear cycle 10, then a fresh clear must give a full window.
        for (int i = 0; i < 4; i++) step(1'b1, 5'(i), 64'hDEAD_0000 + 64'(i), 5'd0, 5'd1, 1'b0);
        step(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b1);
        for (int k = 1; k < 10; k++) step(1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0);
        reset_now_and_check("mid_clr_rst");
        busy_window("restart", 1'b0);

        // Random traffic with occasional clear requests.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file for the LEGv8 datapath: the next generation of the processor's register file. One write port and `NUM_RD` read ports, all on a single rising clock edge. Adds an asynchronous reset, a hardwired zero register, optional write-to-read bypass, and a sequential clear engine with a busy handshake. Sits between instruction decode (register numbers) and the ALU operand latches, in both the multicycle and pipelined cores.

## Interface
Parameters:
- `DATA_W`, 64: register width in bits.
- `ADDR_W`, 5: register-number width; depth is `DEPTH = 2**ADDR_W`.
- `NUM_RD`, 2: number of read ports, 1..4.
- `ZERO_REG`, 31: index hardwired to zero (XZR); -1 disables the zero register.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears everything.
- `reg_write`  in  1  write enable.
- `wn`  in  ADDR_W  write register number.
- `wd`  in  DATA_W  write data.
- `rn`  in  NUM_RD*ADDR_W  read register numbers; port i at bits [i*ADDR_W +: ADDR_W].
- `rd`  out  NUM_RD*DATA_W  registered read data; port i at bits [i*DATA_W +: DATA_W].
- `clear_req`  in  1  one-cycle pulse requesting a full clear.
- `busy`  out  1  high while the clear engine runs.

## Operation
- Storage: `DEPTH` x `DATA_W` array.
- Write: on a rising edge with `reg_write`=1, `busy`=0 and `wn`!=`ZERO_REG`, the array entry at `wn` takes `wd`.
  - Writes to `ZERO_REG` are discarded.
  - `reg_write` is ignored while `busy`=1.
- Read: on every rising edge, each `rd[i]` registers the array entry at `rn[i]`.
  - If `rn[i]`==`ZERO_REG`, `rd[i]` registers 0.
  - If `busy`=1, `rd[i]` registers 0.
  - Ports are independent; several ports may address the same register.
- Read/write same edge, same register, not the zero register: with bypass compiled in (see Configuration), `rd[i]` takes `wd`.
- Clear engine, FSM with two states:
  - `IDLE`: if `clear_req`=1, go to `CLEAR`, load counter with 0 and assert `busy`.
  - `CLEAR`: each cycle writes 0 to entry `counter`, then increments the counter. After writing entry `DEPTH-1`, return to `IDLE` and drop `busy`.
  - `clear_req` is ignored in `CLEAR` and is not queued.
  - The counter is `ADDR_W` bits wide; the last entry is detected by comparison, not by wrap.
- Reset, asserted at any time including mid-clear:
  - all array entries, all `rd` = 0;
  - state = `IDLE`, counter = 0, `busy` = 0.
  - Takes effect immediately, without waiting for a clock edge.

## Timing
- Read latency: 1 cycle. `rn` is sampled at edge N and the data is valid on `rd` after edge N.
- Write visibility:
  - Data written at edge N is readable through the array at edge N+1 or later.
  - At edge N itself, the read returns the bypassed value or the old value, per Configuration.
- Clear engine:
  - `clear_req` sampled high at edge N → `busy`=1 after edge N.
  - Entries 0..DEPTH-1 are cleared at edges N+1..N+DEPTH.
  - `busy`=0 after edge N+DEPTH.
  - Total busy window: `DEPTH` cycles (32 at default).
- First normal write is accepted at edge N+DEPTH+1.
- Reset values: `rd`=0, `busy`=0.

## Configuration
- Macro: `REG_FILE_BYPASS_EN`.
- Defined: same-edge write-to-read forwarding.
  - If `reg_write`=1, `busy`=0, `wn`==`rn[i]` and `wn`!=`ZERO_REG`, `rd[i]` registers `wd`.
  - Required for the pipelined core, where writeback and decode overlap.
- Undefined: read-before-write; `rd[i]` registers the pre-write array value. This matches the multicycle core, where the same register is never read and written in one cycle.

## Test plan
- Reset: assert `reset` between edges → `rd`=0 and `busy`=0 without a clock edge. After release, reading X5 returns 0.
- Write/read: write X3=0x0123_4567_89AB_CDEF, then next cycle read X3 on port 0 and X3 on port 1 → both equal 0x0123_4567_89AB_CDEF one cycle later.
- Zero register: write X31=0xFFFF_FFFF_FFFF_FFFF, then read X31 → 0. Repeat with `ZERO_REG`=-1 → 0xFFFF_FFFF_FFFF_FFFF.
- Same-edge hazard: X7=0x11 preloaded; write X7=0x22 while reading X7 → 0x22 with `REG_FILE_BYPASS_EN`, 0x11 without. Both builds read 0x22 on the following cycle.
- Clear engine: fill X0..X30 with nonzero values, pulse `clear_req` → `busy` high for exactly 32 cycles.
  - `reg_write` of X1=0x55 mid-clear is dropped.
  - Second `clear_req` mid-clear is ignored.
  - Afterwards, every register reads 0.
- Reset mid-clear: assert `reset` at clear cycle 10 → `busy`=0 immediately and the FSM is in `IDLE`. A new `clear_req` restarts from entry 0 with a full 32-cycle busy window.
